// File: rtl/bsg_fsb_seq_pkg.sv
// Shared definitions for the FSB boot sequencer: command opcodes, the
// sequencer state encoding and the command-packet builder.
package bsg_fsb_seq_pkg;

    // Widest FSB packet the command builder can format.
    localparam int unsigned fsb_max_width_lp = 512;

    localparam logic [7:0] op_reset_on  = 8'h03;
    localparam logic [7:0] op_reset_off = 8'h04;
    localparam logic [7:0] op_enable    = 8'h01;

    typedef enum logic [2:0] {
        RST_ON  = 3'd0,
        HOLD    = 3'd1,
        RST_OFF = 3'd2,
        EN      = 3'd3,
        NEXT    = 3'd4,
        PASS    = 3'd5
    } seq_state_e;

    // Command packet: id in the top id_width bits, cmd bit just below,
    // opcode in the low byte, everything else zero.
    function automatic logic [fsb_max_width_lp-1:0] fsb_cmd_pkt(
        input int unsigned width,
        input int unsigned id_width,
        input logic [15:0] id,
        input logic [7:0]  opcode
    );
        logic [fsb_max_width_lp-1:0] id_mask;
        logic [fsb_max_width_lp-1:0] pkt;
        id_mask = (fsb_max_width_lp'(1) << id_width) - fsb_max_width_lp'(1);
        pkt = ((fsb_max_width_lp'(id) & id_mask) << (width - id_width))
            | (fsb_max_width_lp'(1) << (width - id_width - 1))
            | fsb_max_width_lp'(opcode);
        return pkt;
    endfunction

endpackage

// File: rtl/bsg_fsb_seq_cmd_gen.sv
// Command packet formatter and reset-hold counter for the boot sequencer.
// Ports:
//   clk_i, reset_n_i  clock and async active-low reset
//   state_i, idx_i    current sequencer state and node index
//   hold_clr_i        restart the hold count (RST_ON accepted)
//   hold_inc_i        count one hold cycle
//   pkt_o             formatted command packet for the current state/node
//   hold_last_o       final hold cycle reached
module bsg_fsb_seq_cmd_gen
    import bsg_fsb_seq_pkg::*;
#(
    parameter int unsigned width_p       = 16,
    parameter int unsigned id_width_p    = 4,
    parameter int unsigned idx_width_p   = 2,
    parameter int unsigned hold_cycles_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  seq_state_e             state_i,
    input  logic [idx_width_p-1:0] idx_i,
    input  logic                   hold_clr_i,
    input  logic                   hold_inc_i,
    output logic [width_p-1:0]     pkt_o,
    output logic                   hold_last_o
);

    localparam int unsigned hold_width_lp = $clog2(hold_cycles_p + 1);

    logic [hold_width_lp-1:0] hold_cnt_q;
    logic [7:0]               opcode;

    // Opcode by state; non-command states carry a zero opcode.
    always_comb begin
        opcode = 8'h00;
        unique case (state_i)
            RST_ON:  opcode = op_reset_on;
            RST_OFF: opcode = op_reset_off;
            EN:      opcode = op_enable;
            default: opcode = 8'h00;
        endcase
    end

    assign pkt_o = width_p'(fsb_cmd_pkt(width_p, id_width_p, 16'(idx_i), opcode));

    // Hold counter; the counter width leaves room for the wrap-free final increment.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hold_cnt_q <= '0;
        end else if (hold_clr_i) begin
            hold_cnt_q <= '0;
        end else if (hold_inc_i) begin
            hold_cnt_q <= hold_cnt_q + hold_width_lp'(1);
        end
    end

    assign hold_last_o = (hold_cnt_q == hold_width_lp'(hold_cycles_p - 1));

endmodule

// File: rtl/bsg_fsb_node_sequencer.sv
// Boot/re-boot controller between the assembler stream and the FSB input
// channel. Injects reset-on / hold / reset-off / optional enable commands per
// node, then becomes a pure passthrough for the assembler.
// Ports:
//   clk_i, reset_n_i          clock and async active-low reset
//   start_i                   restart the boot sequence (honoured in PASS only)
//   asm_v_i/asm_data_i/asm_yumi_o   assembler side
//   fsb_v_o/fsb_data_o/fsb_yumi_i   FSB side
//   node_reset_r_o, node_en_r_o     shadow per-node reset/enable
//   busy_o                    high while sequencing
module bsg_fsb_node_sequencer
    import bsg_fsb_seq_pkg::*;
#(
    parameter int unsigned         width_p       = 16,
    parameter int unsigned         nodes_p       = 4,
    parameter logic [nodes_p-1:0]  en_mask_p     = {nodes_p{1'b1}},
    parameter int unsigned         hold_cycles_p = 16,
    parameter int unsigned         id_width_p    = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               start_i,
    input  logic               asm_v_i,
    input  logic [width_p-1:0] asm_data_i,
    output logic               asm_yumi_o,
    output logic               fsb_v_o,
    output logic [width_p-1:0] fsb_data_o,
    input  logic               fsb_yumi_i,
    output logic [nodes_p-1:0] node_reset_r_o,
    output logic [nodes_p-1:0] node_en_r_o,
    output logic               busy_o
);

    localparam int unsigned idx_width_lp = (nodes_p > 1) ? $clog2(nodes_p) : 1;

    seq_state_e                state_q;
    logic [idx_width_lp-1:0]   idx_q;
    logic [nodes_p-1:0]        node_reset_q;
    logic [nodes_p-1:0]        node_en_q;
    logic [nodes_p-1:0]        idx_onehot;
    logic                      en_sel;
    logic [width_p-1:0]        cmd_pkt;
    logic                      hold_last;

    assign idx_onehot = nodes_p'(1) << idx_q;
    assign en_sel     = |(en_mask_p & idx_onehot);

    bsg_fsb_seq_cmd_gen #(
        .width_p       (width_p),
        .id_width_p    (id_width_p),
        .idx_width_p   (idx_width_lp),
        .hold_cycles_p (hold_cycles_p)
    ) u_cmd_gen (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .state_i     (state_q),
        .idx_i       (idx_q),
        .hold_clr_i  ((state_q == RST_ON) && fsb_yumi_i),
        .hold_inc_i  (state_q == HOLD),
        .pkt_o       (cmd_pkt),
        .hold_last_o (hold_last)
    );

    // Sequencer FSM with shadow reset/enable registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= RST_ON;
            idx_q        <= '0;
            node_reset_q <= '1;
            node_en_q    <= '0;
        end else begin
            unique case (state_q)
                RST_ON: begin
                    if (fsb_yumi_i) state_q <= HOLD;
                end
                HOLD: begin
                    if (hold_last) state_q <= RST_OFF;
                end
                RST_OFF: begin
                    if (fsb_yumi_i) begin
                        node_reset_q <= node_reset_q & ~idx_onehot;
                        state_q      <= en_sel ? EN : NEXT;
                    end
                end
                EN: begin
                    if (fsb_yumi_i) begin
                        node_en_q <= node_en_q | idx_onehot;
                        state_q   <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx_q == idx_width_lp'(nodes_p - 1)) begin
                        state_q <= PASS;
                    end else begin
                        idx_q   <= idx_q + idx_width_lp'(1);
                        state_q <= RST_ON;
                    end
                end
                PASS: begin
                    // A coincident passthrough handshake completes this cycle.
                    if (start_i) begin
                        state_q      <= RST_ON;
                        idx_q        <= '0;
                        node_reset_q <= '1;
                        node_en_q    <= '0;
                    end
                end
                default: state_q <= RST_ON;
            endcase
        end
    end

    // Channel mux; valid is gated by reset so nothing is offered while held in reset.
    always_comb begin
        fsb_v_o    = 1'b0;
        fsb_data_o = cmd_pkt;
        asm_yumi_o = 1'b0;
        unique case (state_q)
            RST_ON, RST_OFF, EN: fsb_v_o = reset_n_i;
            PASS: begin
                fsb_v_o    = asm_v_i;
                fsb_data_o = asm_data_i;
                asm_yumi_o = fsb_yumi_i;
            end
            default: fsb_v_o = 1'b0;
        endcase
    end

    assign node_reset_r_o = node_reset_q;
    assign node_en_r_o    = node_en_q;
    assign busy_o         = (state_q != PASS);

endmodule
